// File: rtl/store_buffered_pkg.sv
// Shared helpers for the store_buffered store port.
// Holds the constant functions that size the FIFO pointers and occupancy counter.
package store_buffered_pkg;

  // Read/write pointer width; a single-entry buffer still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold every value 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/store_buffered_fifo.sv
// Circular buffer of Depth entries, each Width bits wide. Depth need not be a
// power of two; pointers wrap explicitly from Depth-1 to 0.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (pointers and count cleared)
//   push_i   write wdata_i at the write pointer (ignored when full)
//   wdata_i  entry to write
//   pop_i    retire the head entry (ignored when empty)
//   rdata_o  head entry; don't-care while empty
//   empty_o  no entries stored
//   count_o  number of stored entries
module store_buffered_fifo
  import store_buffered_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned     PtrW     = ptr_width(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset: contents are only observed while count > 0.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = empty;
  assign count_o = count_q;

endmodule

// File: rtl/store_buffered.sv
// Buffered store port: joins the data and address channels from the circuit,
// queues the joined pairs, and presents the head pair to memory on two
// independently handshaked channels (eager fork).
//
// Optional build macro STORE_BUFFERED_OCC_EN adds the 'occupancy' output
// (registered entry count).
//
// Ports:
//   clk, rst (async, active-low)
//   dataIn/_valid/_ready     store data from the circuit
//   addrIn/_valid/_ready     store address from the circuit
//   dataToMem/_valid/_ready  data to the memory interface
//   addrOut/_valid/_ready    address to the memory interface
//   idle                     buffer empty
//   occupancy                (STORE_BUFFERED_OCC_EN only) stored pair count
module store_buffered
  import store_buffered_pkg::*;
#(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned ADDR_TYPE = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] dataIn,
  input  logic                 dataIn_valid,
  output logic                 dataIn_ready,
  input  logic [ADDR_TYPE-1:0] addrIn,
  input  logic                 addrIn_valid,
  output logic                 addrIn_ready,
  output logic [DATA_TYPE-1:0] dataToMem,
  output logic                 dataToMem_valid,
  input  logic                 dataToMem_ready,
  output logic [ADDR_TYPE-1:0] addrOut,
  output logic                 addrOut_valid,
  input  logic                 addrOut_ready,
  output logic                 idle
`ifdef STORE_BUFFERED_OCC_EN
  ,
  output logic [cnt_width(DEPTH)-1:0] occupancy
`endif
);

  localparam int unsigned     CntW     = cnt_width(DEPTH);
  localparam int unsigned     Width    = DATA_TYPE + ADDR_TYPE;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [CntW-1:0]  count;
  logic [Width-1:0] head;
  logic             full, empty, push, pop;
  logic             data_sent_q, data_sent_d;
  logic             addr_sent_q, addr_sent_d;
  logic             data_done, addr_done;

  // Join: readiness looks only at the registered count, so a same-cycle pop
  // never opens the input when full.
  assign full         = (count == DepthCnt);
  assign dataIn_ready = addrIn_valid & ~full;
  assign addrIn_ready = dataIn_valid & ~full;
  assign push         = dataIn_valid & addrIn_valid & ~full;

  store_buffered_fifo #(
    .Width (Width),
    .Depth (DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i ({dataIn, addrIn}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (count)
  );

  // Eager fork: each channel offers the head until it has handshaked once;
  // the entry retires when both channels are done.
  assign dataToMem       = head[Width-1 -: DATA_TYPE];
  assign addrOut         = head[ADDR_TYPE-1:0];
  assign dataToMem_valid = ~empty & ~data_sent_q;
  assign addrOut_valid   = ~empty & ~addr_sent_q;
  assign data_done       = data_sent_q | (dataToMem_valid & dataToMem_ready);
  assign addr_done       = addr_sent_q | (addrOut_valid & addrOut_ready);
  assign pop             = ~empty & data_done & addr_done;

  always_comb begin
    data_sent_d = data_sent_q;
    addr_sent_d = addr_sent_q;
    if (pop) begin
      data_sent_d = 1'b0;
      addr_sent_d = 1'b0;
    end else begin
      if (dataToMem_valid & dataToMem_ready) data_sent_d = 1'b1;
      if (addrOut_valid & addrOut_ready)     addr_sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sent_q <= 1'b0;
      addr_sent_q <= 1'b0;
    end else begin
      data_sent_q <= data_sent_d;
      addr_sent_q <= addr_sent_d;
    end
  end

  assign idle = empty;

`ifdef STORE_BUFFERED_OCC_EN
  assign occupancy = count;
`endif

endmodule

// File: tb/tb_store_buffered.sv
// Randomized bench for store_buffered with a queue-based reference model.
// The driver issues stimulus after each rising edge; the monitor samples on
// the falling edge, predicts outputs from counts of pushed/sent items, and
// pops expected data/address as each output channel handshakes.
module tb_store_buffered;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dataIn = '0, addrIn = '0;
  logic        dataIn_valid = 1'b0, addrIn_valid = 1'b0;
  logic        dataIn_ready, addrIn_ready;
  logic [31:0] dataToMem, addrOut;
  logic        dataToMem_valid, addrOut_valid;
  logic        dataToMem_ready = 1'b0, addrOut_ready = 1'b0;
  logic        idle;
`ifdef STORE_BUFFERED_OCC_EN
  logic [CntW-1:0] occupancy;
`endif

  store_buffered #(
    .DATA_TYPE (32),
    .ADDR_TYPE (32),
    .DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dataIn          (dataIn),
    .dataIn_valid    (dataIn_valid),
    .dataIn_ready    (dataIn_ready),
    .addrIn          (addrIn),
    .addrIn_valid    (addrIn_valid),
    .addrIn_ready    (addrIn_ready),
    .dataToMem       (dataToMem),
    .dataToMem_valid (dataToMem_valid),
    .dataToMem_ready (dataToMem_ready),
    .addrOut         (addrOut),
    .addrOut_valid   (addrOut_valid),
    .addrOut_ready   (addrOut_ready),
    .idle            (idle)
`ifdef STORE_BUFFERED_OCC_EN
    ,
    .occupancy       (occupancy)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: pairs accepted so far, and how many of them each output
  // channel has delivered. Pending payloads wait in per-channel queues.
  int unsigned np = 0, nd = 0, na = 0;
  logic [31:0] qd[$];
  logic [31:0] qa[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int unsigned h, occ;
    bit          full, exp_dv, exp_av;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        #1;
        chk("rst_data_valid", 32'(dataToMem_valid), 32'd0);
        chk("rst_addr_valid", 32'(addrOut_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
`ifdef STORE_BUFFERED_OCC_EN
        chk("rst_occupancy", 32'(occupancy), 32'd0);
`endif
        np = 0; nd = 0; na = 0;
        qd.delete();
        qa.delete();
      end else begin
        h      = (nd < na) ? nd : na;
        occ    = np - h;
        full   = (occ == DEPTH);
        exp_dv = (h < np) && (nd == h);
        exp_av = (h < np) && (na == h);
        chk("data_valid", 32'(dataToMem_valid), 32'(exp_dv));
        chk("addr_valid", 32'(addrOut_valid), 32'(exp_av));
        chk("idle", 32'(idle), 32'(occ == 0));
        chk("dataIn_ready", 32'(dataIn_ready), 32'(addrIn_valid && !full));
        chk("addrIn_ready", 32'(addrIn_ready), 32'(dataIn_valid && !full));
`ifdef STORE_BUFFERED_OCC_EN
        chk("occupancy", 32'(occupancy), occ);
`endif
        if (exp_dv && dataToMem_valid) begin
          chk("dataToMem", dataToMem, qd[0]);
          if (dataToMem_ready) begin
            void'(qd.pop_front());
            nd++;
          end
        end
        if (exp_av && addrOut_valid) begin
          chk("addrOut", addrOut, qa[0]);
          if (addrOut_ready) begin
            void'(qa.pop_front());
            na++;
          end
        end
        if (dataIn_valid && addrIn_valid && !full) begin
          qd.push_back(dataIn);
          qa.push_back(addrIn);
          np++;
        end
      end
    end
  end

  task automatic set(input bit dv, input bit av, input bit dr, input bit ar,
                     input logic [31:0] d, input logic [31:0] a);
    @(posedge clk);
    #1;
    dataIn_valid    = dv;
    addrIn_valid    = av;
    dataToMem_ready = dr;
    addrOut_ready   = ar;
    dataIn          = d;
    addrIn          = a;
  endtask

  task automatic rnd(input int unsigned n, input int unsigned pin,
                     input int unsigned pd, input int unsigned pa);
    for (int i = 0; i < n; i++) begin
      set($urandom_range(99) < pin, $urandom_range(99) < pin,
          $urandom_range(99) < pd, $urandom_range(99) < pa, $urandom, $urandom);
    end
  endtask

  // Driver
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Lone data valid must not be consumed.
    repeat (3) set(1, 0, 1, 1, 32'hDEAD, 32'hBEEF);

    // Single pair straight through.
    set(1, 1, 1, 1, 32'hA5, 32'h10);
    repeat (3) set(0, 0, 1, 1, '0, '0);

    // Overfill with outputs stalled, then drain in order.
    for (int i = 0; i < 5; i++) set(1, 1, 0, 0, 32'(i + 1), 32'(i * 4));
    repeat (6) set(0, 0, 1, 1, '0, '0);

    // Address channel stalled while data completes.
    set(1, 1, 1, 0, 32'h1, 32'h20);
    repeat (3) set(0, 0, 1, 0, '0, '0);
    repeat (2) set(0, 0, 1, 1, '0, '0);

    // Full with a pop and input valids in the same cycle, then refill.
    for (int i = 0; i < 4; i++) set(1, 1, 0, 0, 32'(i + 100), 32'(i + 200));
    set(1, 1, 1, 1, 32'h300, 32'h400);
    set(1, 1, 0, 0, 32'h301, 32'h401);
    set(0, 0, 0, 0, '0, '0);
    repeat (8) set(0, 0, 1, 1, '0, '0);

    // Randomized phases with varied pressure on each side.
    for (int p = 0; p < 15; p++) begin
      rnd(200, $urandom_range(20, 100), $urandom_range(0, 100), $urandom_range(0, 100));
    end

    // Reset mid-operation with three pairs queued and the head's data sent.
    repeat (8) set(0, 0, 1, 1, '0, '0);
    for (int i = 0; i < 3; i++) set(1, 1, 0, 0, 32'(i + 50), 32'(i + 60));
    set(0, 0, 1, 0, '0, '0);
    @(posedge clk);
    #2;
    dataIn_valid = 1'b0;
    addrIn_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) set(0, 0, 1, 1, '0, '0);

    rnd(300, 60, 50, 50);

    // Final drain.
    repeat (20) set(0, 0, 1, 1, '0, '0);
    @(negedge clk);
    #2;
    chk("drain_data_left", 32'(qd.size()), 32'd0);
    chk("drain_addr_left", 32'(qa.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
